// File: rtl/reg_bus_initiator.sv
// BAR1 one-hot register-bus master: queued read/write requests, single outstanding access, read responses.
// Optional READBACK_VERIFY_EN: every write is followed by a readback and a response flagging mismatches.
module reg_bus_initiator #(
    parameter int IDX_W        = 5,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [IDX_W-1:0]      req_index,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDX_W-1:0]      rsp_index,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_error,
    output logic [(2**IDX_W)-1:0] BAR1,
    output logic                  read_enable,
    output logic                  write_enable,
    output logic [DATA_W-1:0]     bus_write,
    input  logic [DATA_W-1:0]     bus_read,
    output logic                  busy
);

    localparam int BAR_W = 2**IDX_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state;

    logic              fifo_write [FIFO_DEPTH];
    logic [IDX_W-1:0]  fifo_index [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_next;
    logic              push;
    logic              pop;
    logic [BAR_W-1:0]  head_sel;

    logic [CNT_W-1:0]  wait_cnt;
    logic [IDX_W-1:0]  cur_index;
`ifdef READBACK_VERIFY_EN
    logic              cur_write;
    logic [DATA_W-1:0] cur_data;
`endif

    assign push     = req_valid && req_ready;
    assign pop      = (state == S_IDLE) && (count != '0);
    assign head_sel = BAR_W'(1) << fifo_index[rd_ptr];
    assign busy     = (count != '0) || (state != S_IDLE);

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    // req_ready is a register, so a pop while full only reopens the FIFO next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            req_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count_next;
            req_ready <= (count_next != (PTR_W+1)'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_write[wr_ptr] <= req_write;
            fifo_index[wr_ptr] <= req_index;
            fifo_data[wr_ptr]  <= req_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            cur_index    <= '0;
            BAR1         <= '0;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            bus_write    <= '0;
            rsp_valid    <= 1'b0;
            rsp_index    <= '0;
            rsp_rdata    <= '0;
`ifdef READBACK_VERIFY_EN
            cur_write    <= 1'b0;
            cur_data     <= '0;
            rsp_error    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        cur_index <= fifo_index[rd_ptr];
                        BAR1      <= head_sel;
`ifdef READBACK_VERIFY_EN
                        cur_write <= fifo_write[rd_ptr];
                        cur_data  <= fifo_data[rd_ptr];
`endif
                        if (fifo_write[rd_ptr]) begin
                            write_enable <= 1'b1;
                            bus_write    <= fifo_data[rd_ptr];
                            state        <= S_WR;
                        end else begin
                            read_enable <= 1'b1;
                            state       <= S_RD;
                        end
                    end
                end
                S_WR: begin
                    write_enable <= 1'b0;
`ifdef READBACK_VERIFY_EN
                    // BAR1 stays on the same index for the readback strobe.
                    read_enable  <= 1'b1;
                    state        <= S_RD;
`else
                    BAR1         <= '0;
                    state        <= S_IDLE;
`endif
                end
                S_RD: begin
                    read_enable <= 1'b0;
                    BAR1        <= '0;
                    wait_cnt    <= CNT_W'(READ_LATENCY);
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == CNT_W'(1)) begin
                        rsp_rdata <= bus_read;
                        rsp_index <= cur_index;
                        rsp_valid <= 1'b1;
`ifdef READBACK_VERIFY_EN
                        rsp_error <= cur_write && (bus_read != cur_data);
`endif
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef READBACK_VERIFY_EN
    assign rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Directed bench for reg_bus_initiator with a register-block model answering one cycle after read_enable.
module tb_reg_bus_initiator;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [4:0]  req_index;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_index;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] BAR1;
    logic        read_enable;
    logic        write_enable;
    logic [31:0] bus_write;
    logic [31:0] bus_read;
    logic        busy;

    logic [31:0] mem [32];
    logic [31:0] store_mask;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } wr_t;
    wr_t wr_log[$];

    int n_vec = 0;
    int n_err = 0;

    reg_bus_initiator #(
        .IDX_W(5), .DATA_W(32), .READ_LATENCY(1), .FIFO_DEPTH(4)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_index(req_index), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_index(rsp_index),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .BAR1(BAR1), .read_enable(read_enable), .write_enable(write_enable),
        .bus_write(bus_write), .bus_read(bus_read), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic int bar_idx(logic [31:0] b);
        for (int i = 0; i < 32; i++) begin
            if (b[i]) return i;
        end
        return 0;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 | i;
            mem[0]   <= 32'h1234_5678;
            mem[31]  <= 32'hCAFE_0031;
            bus_read <= '0;
        end else begin
            if (write_enable) mem[bar_idx(BAR1)] <= bus_write & store_mask;
            if (read_enable)  bus_read <= mem[bar_idx(BAR1)];
        end
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge and apply the always-true bus rules there.
    task automatic tick();
        @(negedge clock);
        check("strobe_exclusive", 32'(read_enable && write_enable), 0);
        if (read_enable || write_enable)
            check("bar1_onehot", 32'($onehot(BAR1)), 1);
        else
            check("bar1_idle_zero", BAR1, 0);
        if (write_enable) wr_log.push_back('{idx: 5'(bar_idx(BAR1)), data: bus_write});
    endtask

    task automatic push(logic w, logic [4:0] idx, logic [31:0] data);
        logic rdy;
        logic done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_index = idx;
        req_wdata = data;
        for (int i = 0; i < 40 && !done; i++) begin
            rdy = req_ready;
            tick();
            done = rdy;
        end
        req_valid = 1'b0;
        check("push_accepted", 32'(done), 1);
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 40 && !rsp_valid; i++) tick();
        check("rsp_arrived", 32'(rsp_valid), 1);
    endtask

    task automatic wait_re();
        for (int i = 0; i < 40 && !read_enable; i++) tick();
        check("re_arrived", 32'(read_enable), 1);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        tick();
        check("rsp_drop_after_ack", 32'(rsp_valid), 0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int seen;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_index  = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        store_mask = 32'hFFFF_FFFF;
        repeat (3) tick();
        check("rst_bar1", BAR1, 0);
        check("rst_re", 32'(read_enable), 0);
        check("rst_we", 32'(write_enable), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_bus_write", bus_write, 0);
        reset = 1'b0;
        tick();

        // write index 1
        push(1'b1, 5'd1, 32'hA5A5_0001);
        for (int i = 0; i < 20 && !write_enable; i++) tick();
        check("wr_strobe", 32'(write_enable), 1);
        check("wr_bar1", BAR1, 32'h0000_0002);
        check("wr_data", bus_write, 32'hA5A5_0001);
        tick();
        check("wr_strobe_len", 32'(write_enable), 0);
        check("wr_data_hold", bus_write, 32'hA5A5_0001);
`ifdef READBACK_VERIFY_EN
        wait_rsp();
        check("wr_rb_index", 32'(rsp_index), 1);
        check("wr_rb_rdata", rsp_rdata, 32'hA5A5_0001);
        check("wr_rb_error", 32'(rsp_error), 0);
        ack();
`else
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        check("wr_no_rsp", 32'(seen), 0);
`endif

        // read index 0, latency check
        push(1'b0, 5'd0, 32'h0);
        wait_re();
        check("rd_bar1", BAR1, 32'h0000_0001);
        tick();
        check("rd_rsp_early", 32'(rsp_valid), 0);
        tick();
        check("rd_rsp_valid", 32'(rsp_valid), 1);
        check("rd_rdata", rsp_rdata, 32'h1234_5678);
        check("rd_index", 32'(rsp_index), 0);
        check("rd_error", 32'(rsp_error), 0);
        ack();

        // FIFO fill behind a stalled response
        push(1'b0, 5'd3, 32'h0);
        wait_rsp();
        check("blk_rdata", rsp_rdata, 32'h1000_0003);
        wr_log.delete();
        for (int i = 4; i < 8; i++) push(1'b1, 5'(i), 32'hC0DE_0000 | i);
        check("full_ready_low", 32'(req_ready), 0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_index = 5'd8;
        req_wdata = 32'hC0DE_0008;
        repeat (3) begin
            tick();
            check("full_hold_ready", 32'(req_ready), 0);
            check("full_hold_rsp", 32'(rsp_valid), 1);
        end
        check("full_busy", 32'(busy), 1);
        rsp_ready = 1'b1;
        push(1'b1, 5'd8, 32'hC0DE_0008);
        repeat (60) tick();
        rsp_ready = 1'b0;
        check("order_count", 32'(wr_log.size()), 5);
        for (int i = 0; i < 5 && i < wr_log.size(); i++) begin
            check("order_idx", 32'(wr_log[i].idx), 32'(i + 4));
            check("order_data", wr_log[i].data, 32'hC0DE_0000 | (i + 4));
        end
        check("drain_ready", 32'(req_ready), 1);
        check("drain_busy", 32'(busy), 0);

        // index 31 with a long response stall
        push(1'b0, 5'd31, 32'h0);
        wait_rsp();
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 32'(rsp_valid), 1);
            check("stall_rdata", rsp_rdata, 32'hCAFE_0031);
            check("stall_index", 32'(rsp_index), 31);
            check("stall_bar1", BAR1, 0);
            check("stall_re", 32'(read_enable), 0);
            check("stall_we", 32'(write_enable), 0);
            tick();
        end
        ack();

        // reset while waiting for read data
        push(1'b0, 5'd2, 32'h0);
        wait_re();
        tick();
        reset = 1'b1;
        tick();
        check("abort_bar1", BAR1, 0);
        check("abort_re", 32'(read_enable), 0);
        check("abort_rsp_valid", 32'(rsp_valid), 0);
        check("abort_rdata", rsp_rdata, 0);
        check("abort_busy", 32'(busy), 0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        check("abort_no_rsp", 32'(seen), 0);
        push(1'b0, 5'd0, 32'h0);
        wait_rsp();
        check("post_rst_rdata", rsp_rdata, 32'h1234_5678);
        check("post_rst_index", 32'(rsp_index), 0);
        ack();

`ifdef READBACK_VERIFY_EN
        store_mask = 32'h0000_FFFF;
        push(1'b1, 5'd2, 32'hDEAD_BEEF);
        wait_rsp();
        check("rb_index", 32'(rsp_index), 2);
        check("rb_rdata", rsp_rdata, 32'h0000_BEEF);
        check("rb_error", 32'(rsp_error), 1);
        ack();
        store_mask = 32'hFFFF_FFFF;
`endif

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
